// File: rtl/score_display_pkg.sv
// Shared types and constants for the three-digit score display scanner.
package score_display_pkg;

    // Digit slot currently being driven by the scanner.
    typedef enum logic [1:0] {
        ONES  = 2'd0,
        TENS  = 2'd1,
        HUNDS = 2'd2
    } digit_state_e;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // One-hot digit enables.
    localparam logic [2:0] AN_ONES  = 3'b001;
    localparam logic [2:0] AN_TENS  = 3'b010;
    localparam logic [2:0] AN_HUNDS = 3'b100;
    localparam logic [2:0] AN_OFF   = 3'b000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_scanner.sv
// Multiplexed three-digit score display with guard bands, leading-zero
// blanking, tear-free frame capture and a game-over blink episode.
// Outputs are registered from the next-state values so that the pins line
// up exactly with the slot counter (output at slot count k reflects k).
module score_display_scanner
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2,
    parameter int BLINK_HALF = 32,
    parameter int BLINK_REPS = 3
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hundreds,
    input  logic       isGameComplete,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       mode_blinking
);

    localparam int CNT_W = 16;
    localparam int PH_W  = $clog2(BLINK_HALF + 1);
    localparam int RP_W  = $clog2(BLINK_REPS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BLINK_HALF - 1);
    localparam logic [RP_W-1:0]  RP_LAST   = RP_W'(BLINK_REPS - 1);

    digit_state_e     slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hunds_q, hunds_d;
    logic             blink_q, blink_d;
    logic             dark_q, dark_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [RP_W-1:0]  rep_q, rep_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;

    logic             frame_end_s;
    logic [3:0]       digit_s;
    logic [2:0]       an_slot_s;
    logic             blank_s;
    logic [6:0]       seg_dec_s;

    bcd_to_seg7 u_dec (
        .bcd_i (digit_s),
        .seg_o (seg_dec_s)
    );

    // Slot counter and digit sequencing; frame ends on the last HUNDS cycle.
    always_comb begin
        frame_end_s = (slot_q == HUNDS) && (cnt_q == CNT_LAST);
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            case (slot_q)
                ONES:    slot_d = TENS;
                TENS:    slot_d = HUNDS;
                HUNDS:   slot_d = ONES;
                default: slot_d = ONES;
            endcase
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            slot_d = slot_q;
        end
    end

    // Digits are only sampled at the frame boundary so a frame never tears.
    always_comb begin
        ones_d  = ones_q;
        tens_d  = tens_q;
        hunds_d = hunds_q;
        if (frame_end_s) begin
            ones_d  = bcd_ones;
            tens_d  = bcd_tens;
            hunds_d = bcd_hundreds;
        end else begin
            ones_d  = ones_q;
            tens_d  = tens_q;
            hunds_d = hunds_q;
        end
    end

    // Blink episode: a trigger restarts at dark/phase 0 and beats frame counting.
    always_comb begin
        blink_d = blink_q;
        dark_d  = dark_q;
        phase_d = phase_q;
        rep_d   = rep_q;
        if (isGameComplete) begin
            blink_d = 1'b1;
            dark_d  = 1'b1;
            phase_d = {PH_W{1'b0}};
            rep_d   = {RP_W{1'b0}};
        end else if (frame_end_s && blink_q) begin
            if (phase_q == PH_LAST) begin
                phase_d = {PH_W{1'b0}};
                if (dark_q) begin
                    dark_d = 1'b0;
                end else if (rep_q == RP_LAST) begin
                    blink_d = 1'b0;
                    dark_d  = 1'b0;
                    rep_d   = {RP_W{1'b0}};
                end else begin
                    rep_d  = rep_q + RP_W'(1);
                    dark_d = 1'b1;
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            blink_d = blink_q;
        end
    end

    // Select the digit for the upcoming slot and apply leading-zero blanking.
    always_comb begin
        digit_s   = ones_d;
        an_slot_s = AN_ONES;
        blank_s   = 1'b0;
        case (slot_d)
            ONES: begin
                digit_s   = ones_d;
                an_slot_s = AN_ONES;
                blank_s   = 1'b0;
            end
            TENS: begin
                digit_s   = tens_d;
                an_slot_s = AN_TENS;
                blank_s   = (hunds_d == 4'd0) && (tens_d == 4'd0);
            end
            HUNDS: begin
                digit_s   = hunds_d;
                an_slot_s = AN_HUNDS;
                blank_s   = (hunds_d == 4'd0);
            end
            default: begin
                digit_s   = 4'd0;
                an_slot_s = AN_OFF;
                blank_s   = 1'b1;
            end
        endcase
    end

    // Next pin values: dark during guard, blanked digits and blink dark phases.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if ((cnt_d < CNT_GUARD) || blank_s || (blink_d && dark_d)) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end else begin
            seg_d = seg_dec_s;
            an_d  = an_slot_s;
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            slot_q  <= ONES;
            cnt_q   <= {CNT_W{1'b0}};
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            hunds_q <= 4'd0;
            blink_q <= 1'b0;
            dark_q  <= 1'b0;
            phase_q <= {PH_W{1'b0}};
            rep_q   <= {RP_W{1'b0}};
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            hunds_q <= hunds_d;
            blink_q <= blink_d;
            dark_q  <= dark_d;
            phase_q <= phase_d;
            rep_q   <= rep_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg           = seg_q;
    assign an            = an_q;
    assign mode_blinking = blink_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// Self-checking bench for score_display_scanner. The reference model works
// from absolute cycle time since reset release and a count of frame
// boundaries since the last trigger.
module tb_score_display_scanner;

    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int BH    = 2;
    localparam int BR    = 3;
    localparam int FRAME = 3 * SD;

    logic       clk;
    logic       nRst;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hundreds;
    logic       isGameComplete;
    logic [6:0] seg;
    logic [2:0] an;
    logic       mode_blinking;

    int compared;
    int mismatched;

    // model state
    int         t;
    logic [3:0] shown [3];
    bit         active;
    int         b;
    logic [6:0] seg_tbl [16];

    score_display_scanner #(
        .SCAN_DIV   (SD),
        .GUARD      (GD),
        .BLINK_HALF (BH),
        .BLINK_REPS (BR)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .bcd_ones       (bcd_ones),
        .bcd_tens       (bcd_tens),
        .bcd_hundreds   (bcd_hundreds),
        .isGameComplete (isGameComplete),
        .seg            (seg),
        .an             (an),
        .mode_blinking  (mode_blinking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_all(input string tag, input logic [6:0] es, input logic [2:0] ea, input logic em);
        compared++;
        assert (seg === es) else begin
            mismatched++;
            $error("FAIL %s seg t=%0d observed=%h expected=%h", tag, t, seg, es);
        end
        compared++;
        assert (an === ea) else begin
            mismatched++;
            $error("FAIL %s an t=%0d observed=%b expected=%b", tag, t, an, ea);
        end
        compared++;
        assert (mode_blinking === em) else begin
            mismatched++;
            $error("FAIL %s mode_blinking t=%0d observed=%b expected=%b", tag, t, mode_blinking, em);
        end
    endtask

    task automatic check_model(input string tag);
        int p, sl, c;
        bit blank, dark;
        logic [6:0] es;
        logic [2:0] ea;
        p  = t % FRAME;
        sl = p / SD;
        c  = p % SD;
        blank = (sl == 2) ? (shown[2] == 4'd0) :
                (sl == 1) ? ((shown[2] == 4'd0) && (shown[1] == 4'd0)) : 1'b0;
        dark  = active && (((b / BH) % 2) == 0);
        if (c < GD || blank || dark) begin
            es = 7'h00;
            ea = 3'b000;
        end else begin
            es = seg_tbl[shown[sl]];
            ea = 3'(1 << sl);
        end
        check_all(tag, es, ea, active);
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if ((t % FRAME) == FRAME - 1) begin
                shown[0] = bcd_ones;
                shown[1] = bcd_tens;
                shown[2] = bcd_hundreds;
                if (active && !isGameComplete) begin
                    b++;
                    if (b >= 2 * BH * BR) active = 1'b0;
                end
            end
            if (isGameComplete) begin
                active = 1'b1;
                b      = 0;
            end
            t++;
            @(posedge clk);
            #1;
            check_model(tag);
        end
    endtask

    task automatic pulse(input string tag);
        isGameComplete = 1'b1;
        step(tag, 1);
        isGameComplete = 1'b0;
    endtask

    task automatic set_digits(input logic [3:0] h, input logic [3:0] tn, input logic [3:0] o);
        bcd_hundreds = h;
        bcd_tens     = tn;
        bcd_ones     = o;
    endtask

    task automatic model_reset();
        t        = 0;
        shown[0] = 4'd0;
        shown[1] = 4'd0;
        shown[2] = 4'd0;
        active   = 1'b0;
        b        = 0;
    endtask

    initial begin
        seg_tbl[0] = 7'h3F; seg_tbl[1] = 7'h06; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h4F;
        seg_tbl[4] = 7'h66; seg_tbl[5] = 7'h6D; seg_tbl[6] = 7'h7D; seg_tbl[7] = 7'h07;
        seg_tbl[8] = 7'h7F; seg_tbl[9] = 7'h6F;
        for (int k = 10; k < 16; k++) seg_tbl[k] = 7'h40;
        compared   = 0;
        mismatched = 0;
        isGameComplete = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0);

        // reset held
        nRst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 7'h00, 3'b000, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        check_model("reset_release");
        step("reset_scan", 2 * FRAME);

        // capture mid-frame
        step("pre_capture", 10);
        set_digits(4'd1, 4'd2, 4'd3);
        step("capture", 2 * FRAME);

        // blanking and invalid digit
        set_digits(4'd0, 4'd0, 4'd7);
        step("blank_007", 2 * FRAME);
        set_digits(4'd0, 4'd5, 4'd0);
        step("blank_050", 2 * FRAME);
        set_digits(4'd0, 4'd0, 4'hC);
        step("invalid_c", 2 * FRAME);
        set_digits(4'd9, 4'd8, 4'd6);
        step("all_digits", 2 * FRAME);

        // full blink episode
        pulse("blink_trig");
        step("blink_run", 12 * FRAME + 20);
        // restart at frame 5 of a new episode
        pulse("blink_trig2");
        step("blink_mid", 5 * FRAME);
        pulse("blink_restart");
        step("blink_restart_run", 12 * FRAME + 20);

        // pulse coinciding with a frame boundary
        while ((t % FRAME) != FRAME - 1) step("align", 1);
        pulse("blink_on_boundary");
        step("blink_boundary_run", 12 * FRAME + 10);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 10) == 0)
                set_digits(4'd0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
            isGameComplete = ($urandom_range(0, 299) == 0);
            step("random", 1);
        end
        isGameComplete = 1'b0;

        // reset during a lit phase
        set_digits(4'd4, 4'd3, 4'd2);
        step("pre_mid_reset", 2 * FRAME);
        pulse("mid_trig");
        step("to_lit", 2 * FRAME + 12);
        #3;
        nRst = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset_async", 7'h00, 3'b000, 1'b0);
        set_digits(4'd0, 4'd0, 4'd0);
        @(negedge clk);
        nRst = 1'b1;
        step("post_reset_scan", 3 * FRAME);
        set_digits(4'd2, 4'd0, 4'd1);
        step("post_reset_digits", 2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
